pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Per-hart program-counter store and next-PC generator for the barrel pipeline.
- Consumes branch_logic's branch-taken flag plus the jump decode from the execute stage, then writes each hart's next PC back.
- Issues fetch PCs round-robin, one hart per cycle, to the instruction memory.
- Every hart has at most one instruction in flight, so NUM_THREADS must be at least the pipeline depth.

Parameters:
- NUM_THREADS, 16, number of harts; power of two, 2..32.
- RESET_PC, 32'h0000_0000, boot PC loaded into every hart at reset.
- TID_W, $clog2(NUM_THREADS), hart-ID width (derived; do not override).

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  synchronous active-low reset
- i_stall  in  1  global fetch stall
- i_ex_valid  in  1  execute-stage instruction retiring this cycle
- i_ex_tid  in  TID_W  hart of the retiring instruction
- i_ex_pc  in  32  PC of the retiring instruction
- i_ex_imm  in  32  sign-extended immediate (B/J/I form)
- i_ex_rs1  in  32  rs1 value, used for jalr
- i_is_branch_valid  in  1  branch taken (from branch_logic)
- i_is_jal  in  1  jal decode
- i_is_jalr  in  1  jalr decode
- o_fetch_valid  out  1  fetch request valid
- o_fetch_tid  out  TID_W  hart being fetched
- o_fetch_pc  out  32  fetch address
- o_link_addr  out  32  i_ex_pc+4, combinational, for rd writeback on jal/jalr
- o_redirect  out  1  combinational; high when i_ex_valid and (taken branch, jal or jalr)

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset values:
  - pc_mem[all] = RESET_PC
  - rr_tid = 0
  - o_fetch_valid = 0, o_fetch_tid = 0, o_fetch_pc = RESET_PC
- Reset release: the first rising edge with i_rst_n=1 and i_stall=0 registers the fetch for hart 0, so o_fetch_valid=1 one cycle after release.
- Target selection (priority order), with 32-bit modulo-2^32 wrap:
  1. i_is_jalr: (i_ex_rs1 + i_ex_imm) with bit0 cleared
  2. i_is_jal or i_is_branch_valid: i_ex_pc + i_ex_imm
  3. otherwise: i_ex_pc + 4
- Writeback: on an edge with i_ex_valid=1, pc_mem[i_ex_tid] <= target. This is independent of i_stall.
- Fetch (registered, latency 1), on an edge with i_stall=0:
  - o_fetch_tid <= rr_tid
  - o_fetch_pc <= pc_mem[rr_tid]
  - o_fetch_valid <= 1
  - rr_tid <= rr_tid+1, wrapping NUM_THREADS-1 -> 0
- Stall: on an edge with i_stall=1, rr_tid and all fetch outputs hold their values, including o_fetch_valid.
- Forwarding: if i_ex_valid and i_ex_tid == rr_tid on the same edge, o_fetch_pc takes the new target, not the stale pc_mem entry.
- Mid-operation reset: reset wins over a simultaneous writeback. All harts return to RESET_PC and any in-flight writeback is discarded.
- pc_mem is a plain register array; no RAM read latency is allowed.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- When defined:
  - A writeback whose target[1:0] != 0 does not update pc_mem and sets sticky halted[i_ex_tid].
  - Added outputs: o_misalign (1 bit, combinational pulse) and o_halted (NUM_THREADS bits).
  - A halted hart's fetch slots still advance rr_tid but register o_fetch_valid=0.
  - halted bits clear only on reset.
- When not defined: target[1:0] is forced to 2'b00 before writeback, there is no halt state, and the extra ports are absent.

Decomposition:
- Shared package (riscv_core_pkg):
  - NUM_THREADS default and TID_W derivation
  - RESET_PC
  - PC_INC = 32'd4
  - typedef tid_t
  - typedef pc_sel_e {PC_SEL_SEQ, PC_SEL_REL, PC_SEL_JALR}
- Sub-module pc_target_calc (combinational): inputs pc, imm, rs1 and the three decode bits; outputs target, link and pc_sel. The sequencer instantiates it once.

Test Plan:
- Reset release with NUM_THREADS=4, RESET_PC=32'h100, no writebacks -> o_fetch_tid cycles 0,1,2,3,0 with o_fetch_pc=32'h100 each, o_fetch_valid first high 1 cycle after release.
- Sequential: ex tid=2, pc=32'h100, no branch/jump -> pc_mem[2]=32'h104; the next tid-2 fetch shows 32'h104; o_redirect=0.
- Taken branch: tid=1, pc=32'h200, imm=32'hFFFF_FFF0, i_is_branch_valid=1 -> next tid-1 fetch = 32'h1F0; o_redirect=1.
- jalr: rs1=32'h1003, imm=32'h4 -> target 32'h1006 (bit0 cleared); o_link_addr=i_ex_pc+4.
- Forward and stall:
  - writeback tid equals rr_tid on the same edge -> the fetch registers the new target;
  - i_stall high for 3 cycles -> fetch outputs frozen while a writeback still lands in pc_mem.
- With PC_MISALIGN_TRAP_EN: jal target 32'h302 on tid 3 -> o_misalign pulse, pc_mem[3] unchanged, halted[3]=1, tid-3 slots give o_fetch_valid=0 until reset.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the barrel-pipeline core front end.
package riscv_core_pkg;

    localparam int          NUM_THREADS = 16;
    localparam int          TID_W       = $clog2(NUM_THREADS);
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_INC      = 32'd4;

    typedef logic [TID_W-1:0] tid_t;

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_REL,
        PC_SEL_JALR
    } pc_sel_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC and link-address computation for one retiring
// instruction. jalr outranks jal/branch, which outrank the sequential PC.
module pc_target_calc
    import riscv_core_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    input  logic        i_is_branch_valid,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    output logic [31:0] o_target,
    output logic [31:0] o_link,
    output pc_sel_e     o_pc_sel
);

    logic [31:0] jalr_sum;

    // Pick the target source by priority; all sums wrap modulo 2^32.
    always_comb begin
        jalr_sum = i_rs1 + i_imm;
        o_link   = i_pc + PC_INC;
        o_pc_sel = PC_SEL_SEQ;
        o_target = i_pc + PC_INC;
        if (i_is_jalr) begin
            o_pc_sel = PC_SEL_JALR;
            o_target = {jalr_sum[31:1], 1'b0};
        end else if (i_is_jal || i_is_branch_valid) begin
            o_pc_sel = PC_SEL_REL;
            o_target = i_pc + i_imm;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Per-hart PC store and round-robin fetch issue for the barrel pipeline.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned targets halt the
// hart instead of being silently aligned).
module pc_sequencer #(
    parameter int          NUM_THREADS = riscv_core_pkg::NUM_THREADS,
    parameter logic [31:0] RESET_PC    = riscv_core_pkg::RESET_PC,
    parameter int          TID_W       = $clog2(NUM_THREADS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_ex_valid,
    input  logic [TID_W-1:0] i_ex_tid,
    input  logic [31:0]      i_ex_pc,
    input  logic [31:0]      i_ex_imm,
    input  logic [31:0]      i_ex_rs1,
    input  logic             i_is_branch_valid,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                   o_misalign,
    output logic [NUM_THREADS-1:0] o_halted,
`endif
    output logic             o_fetch_valid,
    output logic [TID_W-1:0] o_fetch_tid,
    output logic [31:0]      o_fetch_pc,
    output logic [31:0]      o_link_addr,
    output logic             o_redirect
);

    import riscv_core_pkg::*;

    logic [31:0]      pc_mem_q [NUM_THREADS];
    logic [31:0]      pc_mem_d [NUM_THREADS];
    logic [TID_W-1:0] rr_tid_q, rr_tid_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic [TID_W-1:0] fetch_tid_q, fetch_tid_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;

    logic [31:0]      target;
    logic [31:0]      link;
    pc_sel_e          pc_sel;

    pc_target_calc u_target_calc (
        .i_pc              (i_ex_pc),
        .i_imm             (i_ex_imm),
        .i_rs1             (i_ex_rs1),
        .i_is_branch_valid (i_is_branch_valid),
        .i_is_jal          (i_is_jal),
        .i_is_jalr         (i_is_jalr),
        .o_target          (target),
        .o_link            (link),
        .o_pc_sel          (pc_sel)
    );

    assign o_link_addr = link;
    assign o_redirect  = i_ex_valid && (pc_sel != PC_SEL_SEQ);

`ifdef PC_MISALIGN_TRAP_EN
    logic [NUM_THREADS-1:0] halted_q, halted_d;
    logic                   misalign;

    assign misalign   = i_ex_valid && (target[1:0] != 2'b00);
    assign o_misalign = misalign;
    assign o_halted   = halted_q;

    // Writeback (or halt on misalignment) plus next fetch; reading pc_mem_d
    // and halted_d gives same-edge forwarding to the hart being fetched.
    always_comb begin
        pc_mem_d      = pc_mem_q;
        halted_d      = halted_q;
        rr_tid_d      = rr_tid_q;
        fetch_valid_d = fetch_valid_q;
        fetch_tid_d   = fetch_tid_q;
        fetch_pc_d    = fetch_pc_q;
        if (i_ex_valid) begin
            if (misalign) begin
                halted_d[i_ex_tid] = 1'b1;
            end else begin
                pc_mem_d[i_ex_tid] = target;
            end
        end
        if (!i_stall) begin
            rr_tid_d      = rr_tid_q + TID_W'(1);
            fetch_tid_d   = rr_tid_q;
            fetch_pc_d    = pc_mem_d[rr_tid_q];
            fetch_valid_d = !halted_d[rr_tid_q];
        end
    end
`else
    // Writeback with the low two bits forced to zero, plus next fetch;
    // reading pc_mem_d gives same-edge forwarding to the hart being fetched.
    always_comb begin
        pc_mem_d      = pc_mem_q;
        rr_tid_d      = rr_tid_q;
        fetch_valid_d = fetch_valid_q;
        fetch_tid_d   = fetch_tid_q;
        fetch_pc_d    = fetch_pc_q;
        if (i_ex_valid) begin
            pc_mem_d[i_ex_tid] = target & ~32'h3;
        end
        if (!i_stall) begin
            rr_tid_d      = rr_tid_q + TID_W'(1);
            fetch_tid_d   = rr_tid_q;
            fetch_pc_d    = pc_mem_d[rr_tid_q];
            fetch_valid_d = 1'b1;
        end
    end
`endif

    // State registers; reset discards any writeback on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_mem_q      <= '{default: RESET_PC};
            rr_tid_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_tid_q   <= '0;
            fetch_pc_q    <= RESET_PC;
`ifdef PC_MISALIGN_TRAP_EN
            halted_q      <= '0;
`endif
        end else begin
            pc_mem_q      <= pc_mem_d;
            rr_tid_q      <= rr_tid_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_tid_q   <= fetch_tid_d;
            fetch_pc_q    <= fetch_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign o_fetch_valid = fetch_valid_q;
    assign o_fetch_tid   = fetch_tid_q;
    assign o_fetch_pc    = fetch_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with 4 harts and boot PC 0x100.
// Builds with or without PC_MISALIGN_TRAP_EN.
module tb_pc_sequencer;

    localparam int NT = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_tid;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        fetch_valid;
    logic [1:0]  fetch_tid;
    logic [31:0] fetch_pc;
    logic [31:0] link_addr;
    logic        redirect;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign;
    logic [3:0]  halted;
`endif

    int errors = 0;
    int checks = 0;
    int next_rr = 0;
    int last_tid = -1;

    pc_sequencer #(
        .NUM_THREADS (NT),
        .RESET_PC    (32'h100)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall           (stall),
        .i_ex_valid        (ex_valid),
        .i_ex_tid          (ex_tid),
        .i_ex_pc           (ex_pc),
        .i_ex_imm          (ex_imm),
        .i_ex_rs1          (ex_rs1),
        .i_is_branch_valid (is_br),
        .i_is_jal          (is_jal),
        .i_is_jalr         (is_jalr),
`ifdef PC_MISALIGN_TRAP_EN
        .o_misalign        (misalign),
        .o_halted          (halted),
`endif
        .o_fetch_valid     (fetch_valid),
        .o_fetch_tid       (fetch_tid),
        .o_fetch_pc        (fetch_pc),
        .o_link_addr       (link_addr),
        .o_redirect        (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock edge; tracks which hart the round-robin pointer just fetched.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            next_rr  = 0;
            last_tid = -1;
        end else if (!stall) begin
            last_tid = next_rr;
            next_rr  = (next_rr + 1) % NT;
        end
        #1;
    endtask

    task automatic run_to_fetch(input int t);
        int n;
        n = 0;
        while (last_tid != t && n < 2 * NT) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0;
        ex_tid   = '0;
        ex_pc    = '0;
        ex_imm   = '0;
        ex_rs1   = '0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        clear_ex();
        tick();
        tick();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", fetch_valid);
        end
        checks++;
        if (fetch_tid !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_tid: got %0d expected 0", fetch_tid);
        end
        checks++;
        if (fetch_pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected 00000100", fetch_pc);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_tid !== 2'(i % NT) || fetch_pc !== 32'h100) begin
                errors++;
                $display("[TB] FAIL release_fetch%0d: got v=%b tid=%0d pc=%h expected v=1 tid=%0d pc=00000100",
                         i, fetch_valid, fetch_tid, fetch_pc, i % NT);
            end
        end
    endtask

    task automatic test_sequential();
        ex_valid = 1'b1;
        ex_tid   = 2'd2;
        ex_pc    = 32'h100;
        #1;
        checks++;
        if (redirect !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_redirect: got %b expected 0", redirect);
        end
        checks++;
        if (link_addr !== 32'h104) begin
            errors++;
            $display("[TB] FAIL seq_link: got %h expected 00000104", link_addr);
        end
        tick();
        clear_ex();
        run_to_fetch(2);
        checks++;
        if (fetch_tid !== 2'd2 || fetch_pc !== 32'h104) begin
            errors++;
            $display("[TB] FAIL seq_fetch: got tid=%0d pc=%h expected tid=2 pc=00000104", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_branch();
        ex_valid = 1'b1;
        ex_tid   = 2'd1;
        ex_pc    = 32'h200;
        ex_imm   = 32'hFFFF_FFF0;
        is_br    = 1'b1;
        #1;
        checks++;
        if (redirect !== 1'b1) begin
            errors++;
            $display("[TB] FAIL br_redirect: got %b expected 1", redirect);
        end
        checks++;
        if (link_addr !== 32'h204) begin
            errors++;
            $display("[TB] FAIL br_link: got %h expected 00000204", link_addr);
        end
        tick();
        clear_ex();
        run_to_fetch(1);
        checks++;
        if (fetch_tid !== 2'd1 || fetch_pc !== 32'h1F0) begin
            errors++;
            $display("[TB] FAIL br_fetch: got tid=%0d pc=%h expected tid=1 pc=000001f0", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_jalr();
        // jalr must beat a simultaneous branch flag; 0x1002+3 = 0x1005 -> 0x1004
        ex_valid = 1'b1;
        ex_tid   = 2'd0;
        ex_pc    = 32'h400;
        ex_rs1   = 32'h1002;
        ex_imm   = 32'h3;
        is_jalr  = 1'b1;
        is_br    = 1'b1;
        #1;
        checks++;
        if (redirect !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jalr_redirect: got %b expected 1", redirect);
        end
        checks++;
        if (link_addr !== 32'h404) begin
            errors++;
            $display("[TB] FAIL jalr_link: got %h expected 00000404", link_addr);
        end
        tick();
        clear_ex();
        run_to_fetch(0);
        checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'h1004) begin
            errors++;
            $display("[TB] FAIL jalr_fetch: got tid=%0d pc=%h expected tid=0 pc=00001004", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_forward();
        // Writeback to the hart being fetched on this very edge (hart 1, old 0x1F0)
        ex_valid = 1'b1;
        ex_tid   = 2'(next_rr);
        ex_pc    = 32'h500;
        tick();
        clear_ex();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 || fetch_pc !== 32'h504) begin
            errors++;
            $display("[TB] FAIL fwd_fetch: got v=%b tid=%0d pc=%h expected v=1 tid=1 pc=00000504",
                     fetch_valid, fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_stall();
        stall    = 1'b1;
        ex_valid = 1'b1;
        ex_tid   = 2'd3;
        ex_pc    = 32'h600;
        ex_imm   = 32'h10;
        is_jal   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            clear_ex();
            checks++;
            if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 || fetch_pc !== 32'h504) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got v=%b tid=%0d pc=%h expected v=1 tid=1 pc=00000504",
                         i, fetch_valid, fetch_tid, fetch_pc);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (fetch_tid !== 2'd2 || fetch_pc !== 32'h104) begin
            errors++;
            $display("[TB] FAIL stall_resume: got tid=%0d pc=%h expected tid=2 pc=00000104", fetch_tid, fetch_pc);
        end
        tick();
        checks++;
        if (fetch_tid !== 2'd3 || fetch_pc !== 32'h610) begin
            errors++;
            $display("[TB] FAIL stall_wb: got tid=%0d pc=%h expected tid=3 pc=00000610", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_mid_reset();
        rst_n    = 1'b0;
        ex_valid = 1'b1;
        ex_tid   = 2'd0;
        ex_pc    = 32'h700;
        tick();
        clear_ex();
        checks++;
        if (fetch_valid !== 1'b0 || fetch_tid !== 2'd0 || fetch_pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b tid=%0d pc=%h expected v=0 tid=0 pc=00000100",
                     fetch_valid, fetch_tid, fetch_pc);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0 || fetch_pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL mid_reset_h0: got v=%b tid=%0d pc=%h expected v=1 tid=0 pc=00000100",
                     fetch_valid, fetch_tid, fetch_pc);
        end
        tick();
        checks++;
        if (fetch_tid !== 2'd1 || fetch_pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL mid_reset_h1: got tid=%0d pc=%h expected tid=1 pc=00000100", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_wrap();
        ex_valid = 1'b1;
        ex_tid   = 2'd2;
        ex_pc    = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (link_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_link: got %h expected 00000000", link_addr);
        end
        tick();
        clear_ex();
        run_to_fetch(2);
        checks++;
        if (fetch_tid !== 2'd2 || fetch_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_fetch: got tid=%0d pc=%h expected tid=2 pc=00000000", fetch_tid, fetch_pc);
        end
    endtask

`ifdef PC_MISALIGN_TRAP_EN
    task automatic test_misalign();
        ex_valid = 1'b1;
        ex_tid   = 2'd3;
        ex_pc    = 32'h300;
        ex_imm   = 32'h2;
        is_jal   = 1'b1;
        #1;
        checks++;
        if (misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mis_pulse: got %b expected 1", misalign);
        end
        tick();
        clear_ex();
        #1;
        checks++;
        if (misalign !== 1'b0 || halted !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL mis_halt: got pulse=%b halted=%b expected pulse=0 halted=1000", misalign, halted);
        end
        run_to_fetch(3);
        checks++;
        if (fetch_valid !== 1'b0 || fetch_tid !== 2'd3 || fetch_pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL mis_slot: got v=%b tid=%0d pc=%h expected v=0 tid=3 pc=00000100",
                     fetch_valid, fetch_tid, fetch_pc);
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mis_next: got v=%b tid=%0d expected v=1 tid=0", fetch_valid, fetch_tid);
        end
        run_to_fetch(3);
        checks++;
        if (fetch_valid !== 1'b0 || fetch_tid !== 2'd3) begin
            errors++;
            $display("[TB] FAIL mis_sticky: got v=%b tid=%0d expected v=0 tid=3", fetch_valid, fetch_tid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_forward();
        test_stall();
        test_mid_reset();
        test_wrap();
`ifdef PC_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
